// File: rtl/cdc_hs_sender.sv
// ---------------------------------------------------------------------------
// cdc_hs_sender
//
// Source-domain half of a four-phase req/ack clock-domain crossing.
//
// A word offered on the local valid/ready interface is captured into a
// register and launched toward the foreign domain by raising req_out. The
// foreign side answers on ack_async, which is brought in through a chain of
// SYNC_STAGES flops. The handshake then completes in four phases:
//   req 0->1, ack 0->1, req 1->0, ack 1->0
// Only after the synchronized ack has returned low does the block go back to
// IDLE and accept the next word. data_out is loaded only on an accepting
// edge, so it is stable for the whole handshake and beyond.
//
// A wait counter measures how long the block has been sitting in one wait
// state. When it reaches TIMEOUT cycles, the sticky timeout_err flag sets.
// The handshake is never aborted; the flag is only a stall indicator.
//
// Valid/ready contract (local side):
//   A word transfers on a rising clk edge where in_valid & in_ready are both
//   high. in_ready does not depend on in_valid. A source that sees in_ready
//   low must keep in_valid and in_data steady until the transfer edge.
//
// Parameters:
//   WIDTH        data word width (>= 1)
//   SYNC_STAGES  flops in the ack_async synchronizer (>= 2)
//   TIMEOUT      wait cycles before timeout_err sets; 0 disables the counter
//
// Ports:
//   clk          in   single clock, all logic on posedge
//   reset        in   synchronous, active-high reset
//   in_valid     in   local word offered
//   in_data      in   local word
//   in_ready     out  block can accept a word this cycle
//   req_out      out  registered request toward the foreign domain
//   data_out     out  registered data, stable for the whole handshake
//   ack_async    in   acknowledge from the foreign domain (asynchronous)
//   busy         out  handshake in progress (state is not IDLE)
//   timeout_err  out  sticky stall flag
//   err_clr      in   clears timeout_err on the next edge
//   state_dbg    out  current FSM state, for observation only
// ---------------------------------------------------------------------------
module cdc_hs_sender #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             req_out,
   output logic [WIDTH-1:0] data_out,
   input  logic             ack_async,
   output logic             busy,
   output logic             timeout_err,
   input  logic             err_clr,
   output logic [1:0]       state_dbg
);

   // ------------------------------------------------------------------------
   // FSM encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] REQ_HI = 2'd1;
   localparam logic [1:0] REQ_LO = 2'd2;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       accept;
   logic       in_wait;
   logic       state_chg;

   // ------------------------------------------------------------------------
   // ack synchronizer
   // Plain shift chain. ack_async feeds stage 0 and nothing else, so the only
   // flop that can go metastable is stage 0. The FSM looks at the last stage.
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic                   ack_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_sync_q <= '0;
      end else begin
         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_async};
      end
   end

   assign ack_sync = ack_sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------------
   // Local interface
   // A stale ack (ack_sync still high while IDLE) holds off acceptance.
   // Otherwise the new req rise could be mistaken by the receiver for the
   // tail of the previous handshake.
   // ------------------------------------------------------------------------
   assign in_ready = (state == IDLE) & ~ack_sync & ~reset;
   assign busy     = (state != IDLE);
   assign state_dbg = state;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept    = 1'b1;
               state_nxt = REQ_HI;
            end
         end
         REQ_HI: begin
            if (ack_sync) begin
               state_nxt = REQ_LO;
            end
         end
         REQ_LO: begin
            if (!ack_sync) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign in_wait   = (state == REQ_HI) || (state == REQ_LO);
   assign state_chg = (state_nxt != state);

   // ------------------------------------------------------------------------
   // State, request and data registers
   // req_out comes straight from a flop so the foreign domain never sees a
   // combinational glitch on it. data_out is loaded only on an accepting
   // edge and is cleared by reset, so an interrupted word is not resent.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         req_out  <= 1'b0;
         data_out <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            data_out <= in_data;
            req_out  <= 1'b1;
         end else if ((state == REQ_HI) && ack_sync) begin
            req_out <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stall detection
   // ------------------------------------------------------------------------
   generate
      if (TIMEOUT > 0) begin : gen_timeout
         localparam int CW = $clog2(TIMEOUT + 1);

         logic [CW-1:0] wait_cnt;
         logic          err_set;

         // Set on the edge that completes the TIMEOUT-th cycle spent in
         // one wait state.
         assign err_set = in_wait && (wait_cnt == CW'(TIMEOUT - 1));

         always_ff @(posedge clk) begin
            if (reset) begin
               wait_cnt    <= '0;
               timeout_err <= 1'b0;
            end else begin
               // The count restarts on every state change and on err_clr,
               // so a cleared flag re-arms for a full TIMEOUT period of
               // continued stalling. It saturates at TIMEOUT so a long
               // stall cannot wrap around and fire twice.
               if (state_chg || err_clr) begin
                  wait_cnt <= '0;
               end else if (in_wait && (wait_cnt != CW'(TIMEOUT))) begin
                  wait_cnt <= wait_cnt + CW'(1);
               end

               // A set on the same edge as a clear wins.
               if (err_set) begin
                  timeout_err <= 1'b1;
               end else if (err_clr) begin
                  timeout_err <= 1'b0;
               end
            end
         end
      end else begin : gen_no_timeout
         logic unused_timeout;

         assign unused_timeout = err_clr ^ in_wait ^ state_chg;

         always_ff @(posedge clk) begin
            timeout_err <= 1'b0;
         end
      end
   endgenerate

endmodule

// File: tb/tb_cdc_hs_sender.sv
// ---------------------------------------------------------------------------
// tb_cdc_hs_sender
//
// Bench for cdc_hs_sender with WIDTH=8, SYNC_STAGES=2 and TIMEOUT=16.
//
// The foreign side's ack is either looped back from req_out or forced by
// the bench. A reference model tracks the handshake as a word in flight
// plus the ack delay line, and is compared against the DUT on every
// falling edge. Directed sequences pin exact edge-by-edge values.
// A scoreboard pops each expected word when req_out rises.
// ---------------------------------------------------------------------------
module tb_cdc_hs_sender;

   localparam int WIDTH       = 8;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT     = 16;

   // ------------------------------------------------------------------------
   // Clock / reset / DUT
   // ------------------------------------------------------------------------
   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             req_out;
   logic [WIDTH-1:0] data_out;
   logic             ack_async;
   logic             busy;
   logic             timeout_err;
   logic             err_clr;
   logic [1:0]       state_dbg;

   logic             loop_en;
   logic             ack_force;

   always #5 clk = ~clk;

   assign ack_async = loop_en ? req_out : ack_force;

   cdc_hs_sender #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .req_out     (req_out),
      .data_out    (data_out),
      .ack_async   (ack_async),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_clr     (err_clr),
      .state_dbg   (state_dbg)
   );

   // ------------------------------------------------------------------------
   // Counters and check helper
   // ------------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model
   // Handshake seen as: is a word in flight, and is its request still up.
   // The ack path is a delay line: the value the DUT acts on is the ack
   // level sampled SYNC_STAGES edges earlier.
   // ------------------------------------------------------------------------
   bit             m_ack_q[$];
   bit             m_in_flight;
   bit             m_req;
   logic [WIDTH-1:0] m_data;
   bit             m_err;
   int             m_age;       // cycles spent in the current wait phase
   bit             m_valid = 1'b0;

   initial begin
      bit sync_now;
      bit was_waiting;
      bit phase_moved;
      bit hits_limit;
      for (int i = 0; i < SYNC_STAGES; i++) m_ack_q.push_back(1'b0);
      m_in_flight = 1'b0;
      m_req       = 1'b0;
      m_data      = '0;
      m_err       = 1'b0;
      m_age       = 0;
      forever begin
         @(posedge clk);
         sync_now = m_ack_q[SYNC_STAGES-1];
         if (reset) begin
            m_in_flight = 1'b0;
            m_req       = 1'b0;
            m_data      = '0;
            m_err       = 1'b0;
            m_age       = 0;
            for (int i = 0; i < SYNC_STAGES; i++) m_ack_q[i] = 1'b0;
         end else begin
            was_waiting = m_in_flight;
            phase_moved = 1'b0;
            if (!m_in_flight) begin
               if (in_valid && !sync_now) begin
                  m_data      = in_data;
                  m_req       = 1'b1;
                  m_in_flight = 1'b1;
                  phase_moved = 1'b1;
               end
            end else if (m_req && sync_now) begin
               m_req       = 1'b0;
               phase_moved = 1'b1;
            end else if (!m_req && !sync_now) begin
               m_in_flight = 1'b0;
               phase_moved = 1'b1;
            end
            // This edge completes cycle number m_age+1 of waiting.
            hits_limit = was_waiting && (m_age + 1 == TIMEOUT);
            if (phase_moved || err_clr) m_age = 0;
            else if (was_waiting && m_age < TIMEOUT) m_age++;
            if (hits_limit) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            m_ack_q.push_front(ack_async);
            void'(m_ack_q.pop_back());
         end
         m_valid = 1'b1;
      end
   end

   // Compare process: every falling edge once the model has seen one edge.
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            check("mdl_in_ready", in_ready,
                  !m_in_flight && !m_ack_q[SYNC_STAGES-1] && !reset);
            check("mdl_req_out", req_out, m_req);
            check("mdl_data_out", data_out, m_data);
            check("mdl_busy", busy, m_in_flight);
            check("mdl_timeout_err", timeout_err, m_err);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Scoreboard: expected words, popped when req_out rises
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] exp_q[$];
   logic             prev_req = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (req_out === 1'b1 && prev_req === 1'b0) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_req", 32'd1, 32'd0);
            end else begin
               check("sb_word", data_out, exp_q.pop_front());
            end
         end
         prev_req = req_out;
      end
   end

   // ------------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // in_valid/in_data must already be driven. Returns #1 after the accept edge.
   task automatic wait_accept();
      bit done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            @(posedge clk);
            exp_q.push_back(in_data);
            #1;
            done = 1'b1;
         end
      end
      if (!done) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         tick(1);
         if (busy === 1'b0) done = 1'b1;
      end
      if (!done) check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_req_low();
      bit done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         tick(1);
         if (req_out === 1'b0) done = 1'b1;
      end
      if (!done) check("req_low_timeout", 32'd0, 32'd1);
   endtask

   // Loopback timeline, one row per edge k after the first accept (k=0).
   // ack_sync rises after edge 2, req drops at edge 3, ack_sync falls after
   // edge 5, IDLE after edge 6, so the held second word goes in at edge 7.
   logic       lb_req[9]   = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
   logic       lb_ready[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
   logic [7:0] lb_data[9]  = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                               8'hA5, 8'hA5, 8'h3C, 8'h3C};

   // ------------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------------
   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      err_clr   = 1'b0;
      loop_en   = 1'b0;
      ack_force = 1'b0;

      // Reset: two edges with ack low, everything 0.
      for (int i = 0; i < 2; i++) begin
         tick(1);
         check("rst_in_ready", in_ready, 0);
         check("rst_req_out", req_out, 0);
         check("rst_data_out", data_out, 0);
         check("rst_busy", busy, 0);
         check("rst_timeout_err", timeout_err, 0);
      end
      reset = 1'b0;
      tick(1);
      check("post_rst_in_ready", in_ready, 1);

      // Loopback, two words back to back.
      loop_en  = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      wait_accept();
      in_data  = 8'h3C;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) tick(1);
         check("lb_req_out", req_out, lb_req[k]);
         check("lb_data_out", data_out, lb_data[k]);
         check("lb_in_ready", in_ready, lb_ready[k]);
         if (k == 7) begin
            exp_q.push_back(8'h3C);
            in_valid = 1'b0;
         end
      end
      wait_idle();
      loop_en = 1'b0;

      // Stale ack held from reset release.
      reset     = 1'b1;
      ack_force = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(2);
      in_valid = 1'b1;
      in_data  = 8'h5E;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         check("stale_in_ready", in_ready, 0);
         check("stale_req_out", req_out, 0);
      end
      ack_force = 1'b0;
      tick(1);
      check("stale_rel_1_in_ready", in_ready, 0);
      tick(1);
      check("stale_rel_2_in_ready", in_ready, 1);
      wait_accept();
      in_valid = 1'b0;
      check("stale_acc_req_out", req_out, 1);
      check("stale_acc_data_out", data_out, 8'h5E);
      ack_force = 1'b1;
      wait_req_low();
      ack_force = 1'b0;
      wait_idle();

      // Timeout with ack stuck low; edges counted from the accept edge 0.
      in_valid = 1'b1;
      in_data  = 8'hC3;
      wait_accept();
      in_valid = 1'b0;
      check("to_e0_err", timeout_err, 0);
      tick(15);
      check("to_e15_err", timeout_err, 0);
      check("to_e15_req", req_out, 1);
      tick(1);
      check("to_e16_err", timeout_err, 1);
      check("to_e16_req", req_out, 1);
      check("to_e16_busy", busy, 1);
      tick(3);
      check("to_e19_err", timeout_err, 1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("to_clr_e20_err", timeout_err, 0);
      tick(15);
      check("to_e35_err", timeout_err, 0);
      tick(1);
      check("to_e36_err", timeout_err, 1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("to_clr_e37_err", timeout_err, 0);
      tick(15);
      check("to_e52_err", timeout_err, 0);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check("collision_e53_err", timeout_err, 1);
      check("collision_e53_req", req_out, 1);

      // Reset in the middle of the stalled handshake.
      reset = 1'b1;
      tick(1);
      check("midrst_req_out", req_out, 0);
      check("midrst_data_out", data_out, 0);
      check("midrst_busy", busy, 0);
      check("midrst_timeout_err", timeout_err, 0);
      reset = 1'b0;
      tick(1);
      check("midrst_idle_in_ready", in_ready, 1);
      tick(3);
      check("midrst_no_resend", req_out, 0);

      tick(2);
      check("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
